m1_stream_loader: RTL and testbench
===================================

// Module: m1_stream_loader
// PURPOSE
//  Upstream feeder for Top. Accepts a 32-bit valid/ready input stream and packs every
//  4 beats into one 128-bit word. Writes each packed word into the M1 sram_2R1W write
//  port at consecutive addresses. After the last word is written it raises start to Top.
//  Replaces the bench-side $readmemh preload of M1 in the integrated system.
// PARAMETERS
//  DATA_W     128  SRAM word width; must equal LANES*IN_W
//  IN_W       32   input beat width
//  ADDR_W     16   SRAM address width
//  NUM_WORDS  16   128-bit words per load (>=1)
//  BASE_ADDR  0    first M1 address written
// PORTS
//  clock            in   1       single clock, all state on rising edge
//  reset_n          in   1       asynchronous, active-low reset
//  load_req         in   1       one-cycle request to begin a load
//  abort            in   1       synchronous abort of a load in progress
//  in_valid         in   1       input beat valid
//  in_data          in   IN_W    input beat
//  in_ready         out  1       loader accepts beat this cycle
//  M1_WriteEnable   out  1       M1 write strobe
//  M1_WriteAddress  out  ADDR_W  M1 write address
//  M1_WriteBus      out  DATA_W  M1 write data
//  start            out  1       level start to Top
//  busy             out  1       high in FILL or WRITE
// BEHAVIOUR
//  Reset (reset_n=0, async):
//   - state=IDLE; lane, word count and address cleared.
//   - Every output is 0, including in_ready, start and M1_WriteBus.
//  States:
//   - IDLE: in_ready=0. load_req -> FILL, addr=BASE_ADDR, lane=0, wcnt=0, start=0.
//   - FILL: in_ready=1.
//     - A beat is accepted when in_valid&in_ready. Beat k of a word (k=0..3) goes into
//       bits [DATA_W-1-k*IN_W -: IN_W], so the first beat is the MSBs.
//     - Accepting beat 3 -> WRITE.
//   - WRITE: lasts exactly 1 cycle; in_ready=0.
//     - M1_WriteEnable=1, M1_WriteAddress=addr, M1_WriteBus=packed word.
//     - Next state: if wcnt==NUM_WORDS-1 -> DONE; else wcnt++, addr++, lane=0, -> FILL.
//   - DONE: start=1, held as a level. in_ready=0.
//     - load_req -> start=0 on the next cycle and FILL restarts from BASE_ADDR.
//  Timing:
//   - Write latency: WE is high in the cycle right after the 4th beat is accepted.
//   - Peak throughput: 4 beats per 5 cycles.
//   - start rises the cycle after the final WRITE cycle.
//  Outputs outside WRITE:
//   - M1_WriteEnable=0.
//   - Address and bus hold their last values (don't-care to the SRAM).
//  Boundary conditions:
//   - load_req while busy is ignored; in IDLE/DONE it starts a load.
//   - abort in FILL/WRITE -> IDLE next cycle.
//     - A WRITE cycle coincident with abort still completes its write.
//     - A partially filled word is discarded and never written; start stays 0.
//     - abort in IDLE/DONE is ignored.
//   - abort and load_req in the same cycle: abort wins.
//   - Address arithmetic is modulo 2^ADDR_W (BASE_ADDR+NUM_WORDS may wrap past 0xFFFF).
//   - in_valid while in_ready=0: beat is not consumed; the source must hold it.
//   - Reset mid-load: returns to IDLE immediately. No further writes; start=0.
//   - Lane and word counters are sized to cover LANES-1 and NUM_WORDS-1 without overflow.
// TESTING
//  1. NUM_WORDS=2; load_req; beats 0x0..0x7 back-to-back
//     -> WE at addr0 with data 00000000_00000001_00000002_00000003, one cycle after beat 3.
//     -> addr1 = 00000004_..._00000007. start=1 the cycle after the second WE.
//  2. Same data with in_valid toggling every other cycle
//     -> identical SRAM contents; in_ready=0 exactly in the WRITE cycles.
//  3. abort after 6 beats
//     -> only addr0 written; IDLE next cycle; start=0, in_ready=0, busy=0.
//  4. reset_n pulsed low after 2 beats
//     -> all outputs 0 asynchronously; a new load writes addr BASE_ADDR with fresh data only.
//  5. load_req during FILL is ignored (wcnt unchanged)
//     -> load_req in DONE drops start next cycle and the first write goes to BASE_ADDR.
//  6. BASE_ADDR=16'hFFFF, NUM_WORDS=2 -> writes at 0xFFFF then 0x0000; start=1.

Source files
------------

// File: rtl/m1_stream_loader.sv
// ---------------------------------------------------------------------------
// m1_stream_loader
//   Packs a narrow valid/ready beat stream into wide words and writes them to
//   consecutive addresses of the M1 SRAM write port. The first beat of a word
//   lands in the MSBs. After NUM_WORDS words have been written, `start` is
//   raised as a level until the next load request.
//
// Ports
//   clock, reset_n       single clock; asynchronous active-low reset
//   load_req             one-cycle pulse, starts a load from IDLE or DONE
//   abort                drops a load in progress (FILL/WRITE) back to IDLE
//   in_valid/in_data     input beat stream
//   in_ready             high in FILL only
//   M1_WriteEnable       one-cycle write strobe (WRITE state)
//   M1_WriteAddress/Bus  write address/data, held between writes
//   start                level, high in DONE
//   busy                 high in FILL or WRITE
// ---------------------------------------------------------------------------

// One lane of the packing register. `laneNext` is the value the lane will
// hold after this cycle, so the final beat can be merged straight into the
// outgoing word without an extra cycle.
module m1_stream_lane #(
    parameter int IN_W     = 32,
    parameter int LANE_W   = 2,
    parameter int LANE_IDX = 0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              accept,
    input  logic [LANE_W-1:0] lane,
    input  logic [IN_W-1:0]   beat,
    output logic [IN_W-1:0]   laneNext
);
    logic [IN_W-1:0] laneQ;
    logic            hit;

    assign hit      = accept && (lane == LANE_W'(LANE_IDX));
    assign laneNext = hit ? beat : laneQ;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) laneQ <= '0;
        else if (hit) laneQ <= beat;
    end
endmodule

module m1_stream_loader #(
    parameter int               DATA_W    = 128,
    parameter int               IN_W      = 32,
    parameter int               ADDR_W    = 16,
    parameter int               NUM_WORDS = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              load_req,
    input  logic              abort,
    input  logic              in_valid,
    input  logic [IN_W-1:0]   in_data,
    output logic              in_ready,
    output logic              M1_WriteEnable,
    output logic [ADDR_W-1:0] M1_WriteAddress,
    output logic [DATA_W-1:0] M1_WriteBus,
    output logic              start,
    output logic              busy
);
    localparam int LANES  = DATA_W / IN_W;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int WCNT_W = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [WCNT_W-1:0] LAST_WORD = WCNT_W'(NUM_WORDS - 1);

    typedef enum logic [1:0] {IDLE, FILL, WRITE, DONE} stateType;

    stateType                     state, nextState;
    logic [LANE_W-1:0]            lane;
    logic [WCNT_W-1:0]            wcnt;
    logic [ADDR_W-1:0]            addr;
    logic                         inFill;
    logic                         accept;
    logic                         lastBeat;
    logic                         lastWord;
    logic                         startLoad;
    logic [LANES-1:0][IN_W-1:0]   laneNext;
    logic [DATA_W-1:0]            packedNext;

    // Acceptance is derived from state rather than from in_ready so the
    // next-state logic never reads one of its own outputs.
    assign inFill   = (state == FILL);
    assign accept   = inFill && in_valid;
    assign lastBeat = accept && (lane == LAST_LANE);
    assign lastWord = (wcnt == LAST_WORD);

    // ---------------- lane registers ----------------
    genvar k;
    generate
        for (k = 0; k < LANES; k++) begin : gLane
            m1_stream_lane #(
                .IN_W    (IN_W),
                .LANE_W  (LANE_W),
                .LANE_IDX(k)
            ) uLane (
                .clock   (clock),
                .reset_n (reset_n),
                .accept  (accept),
                .lane    (lane),
                .beat    (in_data),
                .laneNext(laneNext[k])
            );
            // beat k occupies the k-th slice counting down from the MSB
            assign packedNext[DATA_W-1-k*IN_W -: IN_W] = laneNext[k];
        end
    endgenerate

    // ---------------- FSM ----------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= nextState;
    end

    always_comb begin
        nextState      = state;
        startLoad      = 1'b0;
        in_ready       = 1'b0;
        M1_WriteEnable = 1'b0;
        start          = 1'b0;
        busy           = 1'b0;
        case (state)
            IDLE: begin
                // abort beats a coincident load_req
                if (load_req && !abort) begin
                    nextState = FILL;
                    startLoad = 1'b1;
                end
            end
            FILL: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (abort)         nextState = IDLE;
                else if (lastBeat) nextState = WRITE;
            end
            WRITE: begin
                // the strobe is issued even when abort arrives this cycle
                M1_WriteEnable = 1'b1;
                busy           = 1'b1;
                if (abort)         nextState = IDLE;
                else if (lastWord) nextState = DONE;
                else               nextState = FILL;
            end
            DONE: begin
                start = 1'b1;
                if (load_req && !abort) begin
                    nextState = FILL;
                    startLoad = 1'b1;
                end
            end
            default: nextState = IDLE;
        endcase
    end

    // ---------------- datapath ----------------
    // Address/bus are captured together with the final beat so they hold
    // steady between writes while `addr` already advances for the next word.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            lane            <= '0;
            wcnt            <= '0;
            addr            <= '0;
            M1_WriteAddress <= '0;
            M1_WriteBus     <= '0;
        end else if (startLoad) begin
            lane <= '0;
            wcnt <= '0;
            addr <= BASE_ADDR;
        end else if (inFill && accept && !abort) begin
            lane <= lastBeat ? '0 : lane + LANE_W'(1);
            if (lastBeat) begin
                M1_WriteAddress <= addr;
                M1_WriteBus     <= packedNext;
            end
        end else if (state == WRITE && !abort && !lastWord) begin
            wcnt <= wcnt + WCNT_W'(1);
            addr <= addr + ADDR_W'(1);   // wraps modulo 2^ADDR_W
            lane <= '0;
        end
    end
endmodule

// File: tb/tb_m1_stream_loader.sv
module tb_m1_stream_loader;
    localparam int          DATA_W    = 128;
    localparam int          IN_W      = 32;
    localparam int          ADDR_W    = 16;
    localparam int          NUM_WORDS = 3;
    localparam logic [15:0] BASE      = 16'hFFFE;   // third word wraps to 0x0000

    logic              clock = 1'b0;
    logic              reset_n = 1'b1;
    logic              load_req = 1'b0;
    logic              abort = 1'b0;
    logic              in_valid = 1'b0;
    logic [IN_W-1:0]   in_data = '0;
    logic              in_ready;
    logic              M1_WriteEnable;
    logic [ADDR_W-1:0] M1_WriteAddress;
    logic [DATA_W-1:0] M1_WriteBus;
    logic              start;
    logic              busy;

    m1_stream_loader #(
        .DATA_W(DATA_W), .IN_W(IN_W), .ADDR_W(ADDR_W),
        .NUM_WORDS(NUM_WORDS), .BASE_ADDR(BASE)
    ) dut (
        .clock(clock), .reset_n(reset_n), .load_req(load_req), .abort(abort),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .M1_WriteEnable(M1_WriteEnable), .M1_WriteAddress(M1_WriteAddress),
        .M1_WriteBus(M1_WriteBus), .start(start), .busy(busy)
    );

    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic [15:0]  addr;
        logic [127:0] data;
    } wrT;

    wrT expQ[$];
    wrT wrLog[$];
    wrT monE;

    // ---------------- reference model ----------------
    // Transaction view: a load is a list of accepted beats; every four beats
    // form one word, written the cycle after, to BASE+index (16-bit wrap).
    bit          mActive = 0, mWritePend = 0, mStart = 0, mTook = 0;
    int          mWordIdx = 0, mLoadBeats = 0;
    logic [31:0] mBeats[$];

    initial forever begin
        @(posedge clock or negedge reset_n);
        if (!reset_n) begin
            mActive = 0; mWritePend = 0; mStart = 0; mTook = 0;
            mBeats.delete();
        end else begin
            mTook = mActive && !mWritePend && in_valid;
            if (mActive) begin
                if (mTook) begin
                    mBeats.push_back(in_data);
                    mLoadBeats++;
                end
                if (abort) begin
                    mActive = 0; mWritePend = 0;
                    mBeats.delete();
                end else if (mWritePend) begin
                    mWritePend = 0;
                    if (mWordIdx == NUM_WORDS - 1) begin
                        mActive = 0; mStart = 1;
                    end else mWordIdx++;
                end else if (mBeats.size() == 4) begin
                    wrT w;
                    w.addr = 16'(int'(BASE) + mWordIdx);
                    w.data = {mBeats[0], mBeats[1], mBeats[2], mBeats[3]};
                    expQ.push_back(w);
                    mBeats.delete();
                    mWritePend = 1;
                end
            end else if (load_req && !abort) begin
                mActive = 1; mStart = 0; mWordIdx = 0; mLoadBeats = 0;
                mBeats.delete();
            end
        end
    end

    // ---------------- monitor ----------------
    initial forever begin
        @(negedge clock);
        chk("in_ready", in_ready, mActive && !mWritePend);
        chk("busy", busy, mActive);
        chk("start", start, mStart);
        chk("we", M1_WriteEnable, mWritePend);
        if (M1_WriteEnable) begin
            monE.addr = M1_WriteAddress;
            monE.data = M1_WriteBus;
            wrLog.push_back(monE);
            if (expQ.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h want none", M1_WriteAddress, M1_WriteBus);
            end else begin
                monE = expQ.pop_front();
                chk("wr_addr", M1_WriteAddress, monE.addr);
                chk("wr_data", M1_WriteBus, monE.data);
            end
        end
    end

    // ---------------- driver ----------------
    bit          seqMode = 0;
    bit          lastTook = 0;
    logic [31:0] seqCnt = 0;

    // Sets inputs for one cycle (called at posedge+1); an offered beat that
    // was not taken is held unchanged.
    task automatic cyc(input bit lr, input bit ab, input int validPct);
        if (!(in_valid && !lastTook)) begin
            in_valid = ($urandom_range(99) < validPct);
            if (in_valid) begin
                if (seqMode) begin
                    in_data = seqCnt;
                    seqCnt  = seqCnt + 1;
                end else in_data = $urandom();
            end
        end
        load_req = lr;
        abort    = ab;
        @(posedge clock); #1;
        lastTook = mTook;
        load_req = 0;
        abort    = 0;
    endtask

    task automatic checkAllZero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_we"}, M1_WriteEnable, 0);
        chk({tag, "_addr"}, M1_WriteAddress, 0);
        chk({tag, "_bus"}, M1_WriteBus, 0);
        chk({tag, "_start"}, start, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    task automatic pulseReset();
        #2 reset_n = 0;
        in_valid = 0; load_req = 0; abort = 0; lastTook = 0;
        #1 checkAllZero("midrst");
        #3 reset_n = 1;
        @(posedge clock); #1;
        lastTook = mTook;
    endtask

    task automatic runLoad(input bit seq, input int validPct, input int lrPct,
                           input int abortBeats, input int abortWord, input int resetBeats);
        int budget;
        budget  = 400;
        seqMode = seq;
        cyc(1, 0, validPct);
        while (mActive && budget > 0) begin
            if (resetBeats > 0 && mLoadBeats == resetBeats) begin
                pulseReset();
                return;
            end
            cyc(($urandom_range(99) < lrPct),
                (abortBeats > 0 && mLoadBeats == abortBeats && !mWritePend) ||
                (abortWord >= 0 && mWritePend && mWordIdx == abortWord),
                validPct);
            budget--;
        end
        if (budget == 0) begin
            checks++; errors++;
            $display("FAIL load_timeout: got busy after 400 cycles want completion");
        end
    endtask

    initial begin
        #1 reset_n = 0;
        #21 checkAllZero("rst");
        reset_n = 1;
        @(posedge clock); #1;

        // back-to-back sequential beats 0..11
        runLoad(1, 100, 0, 0, -1, 0);
        chk("t1_count", wrLog.size(), 3);
        if (wrLog.size() >= 3) begin
            chk("t1_addr0", wrLog[0].addr, 16'hFFFE);
            chk("t1_data0", wrLog[0].data, 128'h00000000_00000001_00000002_00000003);
            chk("t1_addr1", wrLog[1].addr, 16'hFFFF);
            chk("t1_addr2", wrLog[2].addr, 16'h0000);
            chk("t1_data2", wrLog[2].data, 128'h00000008_00000009_0000000A_0000000B);
        end

        // DONE: beats not consumed, abort ignored, start held
        repeat (6) cyc(0, 1'($urandom_range(1)), 60);

        // restart from DONE, gappy input, load_req noise during the load
        runLoad(0, 50, 30, 0, -1, 0);
        // abort after 6 beats: only first word written
        runLoad(0, 100, 0, 6, -1, 0);
        repeat (4) cyc(0, 0, 50);
        cyc(1, 1, 50);                   // abort wins over load_req in IDLE
        repeat (3) cyc(0, 0, 50);
        // abort in the second WRITE cycle: that write still lands
        runLoad(0, 70, 0, 0, 1, 0);
        // reset after 2 beats, then a clean load
        runLoad(0, 100, 0, 0, -1, 2);
        repeat (2) cyc(0, 0, 50);
        runLoad(0, 60, 20, 0, -1, 0);
        repeat (3) cyc(0, 1, 50);        // abort in DONE ignored
        repeat (3) cyc(0, 0, 0);

        chk("expq_empty", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
